// File: rtl/pu_topic_io_req.sv
// PU-side requester for the topic PD memory: captures one PU access, issues it,
// waits for the completion (or a timeout) and returns read/atomic data to the PU.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

package pu_topic_io_pkg;
    typedef struct packed {
        logic [15:0]                 addr;
        logic [3:0]                  tid;
        logic                        wr;
        logic                        atomic;
        logic [4:0]                  funct5;
        logic [`PU_WIDTH_NBITS-1:0]  wdata;
    } io_type;
endpackage

module pu_topic_io_req
    import pu_topic_io_pkg::*;
#(
    parameter int WIDTH_NBITS    = `PU_WIDTH_NBITS,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pu_req,
    input  io_type                 pu_cmd,
    output logic                   pu_stall,
    output logic [WIDTH_NBITS-1:0] pu_rdata,
    output logic                   pu_rdata_valid,
    output logic                   io_req,
    output io_type                 io_cmd,
    input  logic                   io_ack,
    input  logic [WIDTH_NBITS-1:0] io_ack_data,
    output logic                   timeout_err,
    output logic                   spurious_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    state_t                 state_q, state_d;
    logic [9:0]             cnt_q;
    io_type                 io_cmd_q;
    logic [WIDTH_NBITS-1:0] rdata_q;
    logic                   timeout_err_q;
    logic                   spurious_q;

    logic timeoutHit;
    logic returnsData;

    // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle; an ack in that cycle wins.
    assign timeoutHit  = (state_q == WAIT) && (cnt_q == CNT_LAST);
    assign returnsData = !io_cmd_q.wr || io_cmd_q.atomic;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pu_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (io_ack || timeoutHit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            io_cmd_q      <= '0;
            rdata_q       <= '0;
            timeout_err_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timeout_err_q <= timeoutHit && !io_ack;
            spurious_q    <= io_ack && (state_q != WAIT);
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 10'd1;
            end
            if (state_q == IDLE && pu_req) begin
                io_cmd_q <= pu_cmd;
            end
            // Writes complete silently, so pu_rdata only moves when data is returned.
            if (state_q == WAIT && returnsData) begin
                if (io_ack) begin
                    rdata_q <= io_ack_data;
                end else if (timeoutHit) begin
                    rdata_q <= '0;
                end
            end
        end
    end

    assign io_req         = (state_q == ISSUE);
    assign io_cmd         = io_cmd_q;
    assign pu_stall       = (state_q != IDLE);
    assign pu_rdata       = rdata_q;
    assign pu_rdata_valid = (state_q == RESP) && returnsData;
    assign timeout_err    = timeout_err_q;
    assign spurious_ack   = spurious_q;

endmodule

// File: tb/tb_pu_topic_io_req.sv
// Directed self-checking bench for pu_topic_io_req (TIMEOUT_CYCLES reduced to 8).
module tb_pu_topic_io_req;
    import pu_topic_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pu_req;
    io_type      pu_cmd;
    logic        pu_stall;
    logic [31:0] pu_rdata;
    logic        pu_rdata_valid;
    logic        io_req;
    io_type      io_cmd;
    logic        io_ack;
    logic [31:0] io_ack_data;
    logic        timeout_err;
    logic        spurious_ack;

    int checks   = 0;
    int failures = 0;

    io_type cmdA, cmdB;

    pu_topic_io_req #(.WIDTH_NBITS(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .pu_req(pu_req), .pu_cmd(pu_cmd),
        .pu_stall(pu_stall), .pu_rdata(pu_rdata), .pu_rdata_valid(pu_rdata_valid),
        .io_req(io_req), .io_cmd(io_cmd), .io_ack(io_ack), .io_ack_data(io_ack_data),
        .timeout_err(timeout_err), .spurious_ack(spurious_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag, input logic stall, input logic req,
                              input logic vld, input logic terr, input logic spur);
        check({tag, ".stall"}, 64'(pu_stall), 64'(stall));
        check({tag, ".io_req"}, 64'(io_req), 64'(req));
        check({tag, ".valid"}, 64'(pu_rdata_valid), 64'(vld));
        check({tag, ".timeout"}, 64'(timeout_err), 64'(terr));
        check({tag, ".spurious"}, 64'(spurious_ack), 64'(spur));
    endtask

    initial begin
        rst = 1'b1; pu_req = 1'b0; pu_cmd = '0; io_ack = 1'b0; io_ack_data = '0;
        step(); step();
        checkFlags("reset", 0, 0, 0, 0, 0);
        check("reset.io_cmd", 64'(io_cmd), 64'd0);
        check("reset.rdata", 64'(pu_rdata), 64'd0);
        rst = 1'b0;
        step();

        // Read: req T0, ack T5, data at T6
        cmdA = '0; cmdA.addr = 16'h0010; cmdA.tid = 4'd3;
        pu_req = 1'b1; pu_cmd = cmdA;
        checkFlags("rd.T0", 0, 0, 0, 0, 0);
        step(); pu_req = 1'b0; pu_cmd = '0;
        checkFlags("rd.T1", 1, 1, 0, 0, 0);
        check("rd.T1.io_cmd", 64'(io_cmd), 64'(cmdA));
        step(); checkFlags("rd.T2", 1, 0, 0, 0, 0);
        step(); step();
        step(); io_ack = 1'b1; io_ack_data = 32'h1234ABCD;
        checkFlags("rd.T5", 1, 0, 0, 0, 0);
        step(); io_ack = 1'b0; io_ack_data = '0;
        checkFlags("rd.T6", 1, 0, 1, 0, 0);
        check("rd.T6.rdata", 64'(pu_rdata), 64'h1234ABCD);
        step(); checkFlags("rd.T7", 0, 0, 0, 0, 0);
        check("rd.T7.rdata_hold", 64'(pu_rdata), 64'h1234ABCD);
        check("rd.T7.io_cmd_hold", 64'(io_cmd), 64'(cmdA));

        // Write: ack T4, silent completion, idle at T6
        cmdB = '0; cmdB.addr = 16'h0020; cmdB.wr = 1'b1; cmdB.wdata = 32'h0000CAFE;
        pu_req = 1'b1; pu_cmd = cmdB;
        step(); pu_req = 1'b0;
        checkFlags("wr.T1", 1, 1, 0, 0, 0);
        check("wr.T1.io_cmd", 64'(io_cmd), 64'(cmdB));
        step(); step();
        step(); io_ack = 1'b1; io_ack_data = 32'hDEADBEEF;
        step(); io_ack = 1'b0;
        checkFlags("wr.T5", 1, 0, 0, 0, 0);
        step(); checkFlags("wr.T6", 0, 0, 0, 0, 0);
        check("wr.T6.rdata_hold", 64'(pu_rdata), 64'h1234ABCD);

        // Atomic add: pre-modify value 7 returned
        cmdA = '0; cmdA.wr = 1'b1; cmdA.atomic = 1'b1; cmdA.funct5 = 5'd0; cmdA.wdata = 32'd5;
        pu_req = 1'b1; pu_cmd = cmdA;
        step(); pu_req = 1'b0;
        step(); io_ack = 1'b1; io_ack_data = 32'd7;
        step(); io_ack = 1'b0;
        checkFlags("amo.T3", 1, 0, 1, 0, 0);
        check("amo.T3.rdata", 64'(pu_rdata), 64'd7);
        step(); checkFlags("amo.T4", 0, 0, 0, 0, 0);

        // Timeout: WAIT entered T2, abort visible T10, later ack is spurious
        cmdA = '0; cmdA.addr = 16'h0030;
        pu_req = 1'b1; pu_cmd = cmdA;
        step(); pu_req = 1'b0;
        for (int i = 2; i <= 9; i++) step();
        checkFlags("to.T9", 1, 0, 0, 0, 0);
        step(); checkFlags("to.T10", 1, 0, 1, 1, 0);
        check("to.T10.rdata", 64'(pu_rdata), 64'd0);
        step(); checkFlags("to.T11", 0, 0, 0, 0, 0);
        io_ack = 1'b1; io_ack_data = 32'h99;
        step(); io_ack = 1'b0;
        checkFlags("to.T12", 0, 0, 0, 0, 1);
        check("to.T12.rdata", 64'(pu_rdata), 64'd0);
        step(); checkFlags("to.T13", 0, 0, 0, 0, 0);

        // Ack coinciding with the timeout cycle resolves as ack
        pu_req = 1'b1; pu_cmd = cmdA;
        step(); pu_req = 1'b0;
        for (int i = 2; i <= 8; i++) step();
        step(); io_ack = 1'b1; io_ack_data = 32'h55;
        step(); io_ack = 1'b0;
        checkFlags("tie.T10", 1, 0, 1, 0, 0);
        check("tie.T10.rdata", 64'(pu_rdata), 64'h55);
        step();

        // Back-to-back reads, ack latency 2: io_req at T1 and T6
        cmdA = '0; cmdA.addr = 16'h0040; cmdA.tid = 4'd1;
        cmdB = '0; cmdB.addr = 16'h0044; cmdB.tid = 4'd2;
        pu_req = 1'b1; pu_cmd = cmdA;
        step(); checkFlags("b2b.T1", 1, 1, 0, 0, 0);
        step(); checkFlags("b2b.T2", 1, 0, 0, 0, 0);
        step(); io_ack = 1'b1; io_ack_data = 32'h0000AAAA;
        step(); io_ack = 1'b0; pu_cmd = cmdB;
        checkFlags("b2b.T4", 1, 0, 1, 0, 0);
        check("b2b.T4.rdata", 64'(pu_rdata), 64'hAAAA);
        step(); checkFlags("b2b.T5", 0, 0, 0, 0, 0);
        step(); pu_req = 1'b0;
        checkFlags("b2b.T6", 1, 1, 0, 0, 0);
        check("b2b.T6.io_cmd", 64'(io_cmd), 64'(cmdB));
        step();
        step(); io_ack = 1'b1; io_ack_data = 32'h0000BBBB;
        step(); io_ack = 1'b0;
        checkFlags("b2b.T9", 1, 0, 1, 0, 0);
        check("b2b.T9.rdata", 64'(pu_rdata), 64'hBBBB);
        step();

        // Reset during WAIT abandons the access
        pu_req = 1'b1; pu_cmd = cmdA;
        step(); pu_req = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        checkFlags("rstw.async", 0, 0, 0, 0, 0);
        check("rstw.io_cmd", 64'(io_cmd), 64'd0);
        check("rstw.rdata", 64'(pu_rdata), 64'd0);
        step(); rst = 1'b0;
        checkFlags("rstw.next", 0, 0, 0, 0, 0);
        io_ack = 1'b1; io_ack_data = 32'h77;
        step(); io_ack = 1'b0;
        checkFlags("rstw.spur", 0, 0, 0, 0, 1);
        check("rstw.spur.rdata", 64'(pu_rdata), 64'd0);
        pu_req = 1'b1; pu_cmd = cmdB;
        step(); pu_req = 1'b0;
        checkFlags("rstw.req", 1, 1, 0, 0, 0);
        check("rstw.req.io_cmd", 64'(io_cmd), 64'(cmdB));
        step(); io_ack = 1'b1; io_ack_data = 32'h0BADF00D;
        step(); io_ack = 1'b0;
        checkFlags("rstw.resp", 1, 0, 1, 0, 0);
        check("rstw.resp.rdata", 64'(pu_rdata), 64'h0BADF00D);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
